filter_dispatch_ctrl: RTL



---
 rtl/filter_dispatch_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/filter_dispatch_ctrl.sv
// Filter memory node sequencer: captures a DEPTH_F x DEPTH_F byte filter, then injects one routed packet per row.
// Optional SEND_GAP_EN macro inserts GAP_CYCLES idle cycles before every packet.
module filter_dispatch_ctrl #(
   parameter int NODE          = 11,
   parameter int DEPTH_F       = 5,
   parameter int WIDTH_data    = 8,
   parameter int WIDTH_addr    = 12,
   parameter int WIDTH_packet  = 57,
   parameter int WIDTH_payload = 40,
   parameter int MESH_X        = 5
`ifdef SEND_GAP_EN
   , parameter int GAP_CYCLES  = 12
`endif
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load_start,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [WIDTH_addr-1:0]   wr_addr,
   input  logic [WIDTH_data-1:0]   wr_data,
   input  logic                    load_done,
   output logic                    pkt_valid,
   input  logic                    pkt_ready,
   output logic [WIDTH_packet-1:0] pkt_data,
   output logic                    busy,
   output logic                    addr_err
);

   typedef enum logic [2:0] {IDLE, LOAD, WAIT_DONE, SEND, DONE} state_t;

   localparam int NB = DEPTH_F * DEPTH_F;
   localparam int RW = (DEPTH_F > 1) ? $clog2(DEPTH_F) : 1;
   localparam int CW = $clog2(NB + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(DEPTH_F - 1);

   state_t                                  state_q;
   logic                                    wr_ready_q, pkt_valid_q, addr_err_q;
   logic [WIDTH_packet-1:0]                 pkt_data_q;
   logic [CW-1:0]                           cnt_q;
   logic [RW-1:0]                           row_q;
   logic [DEPTH_F-1:0][WIDTH_payload-1:0]   bank_q;

   logic          beat, addr_ok, send_go;
   logic [RW-1:0] wr_row, wr_col;

   // Range check uses the full address so wrapped indices can never alias a real row.
   assign addr_ok = wr_addr < WIDTH_addr'(NB);
   assign wr_row  = RW'(wr_addr / WIDTH_addr'(DEPTH_F));
   assign wr_col  = RW'(wr_addr % WIDTH_addr'(DEPTH_F));
   assign beat    = wr_valid & wr_ready_q;

`ifdef SEND_GAP_EN
   localparam int GW = $clog2(GAP_CYCLES + 2);
   localparam logic [GW-1:0] GAP_INIT = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   logic [GW-1:0] gap_q;

   // Counter idles at GAP_INIT and only runs down while SEND waits to present a packet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              gap_q <= GAP_INIT;
      else if (state_q != SEND || pkt_valid_q) gap_q <= GAP_INIT;
      else if (gap_q != '0)                    gap_q <= gap_q - GW'(1);
   end

   assign send_go = !pkt_valid_q && (gap_q == '0);
`else
   assign send_go = !pkt_valid_q;
`endif

   function automatic logic [WIDTH_packet-1:0] build_pkt(input logic [RW-1:0] r,
                                                          input logic [WIDTH_payload-1:0] pl);
      int s, d, sx, dx;
      logic [WIDTH_packet-1:0] p;
      s  = NODE - 1;
      d  = int'(r);
      sx = s % MESH_X;
      dx = d % MESH_X;
      p  = '0;
      p[WIDTH_payload-1:0] = pl;
      p[55:52] = 4'(NODE);
      p[51:48] = 4'(d + 1);
      if (dx > sx) begin
         p[47]    = 1'b1;
         p[46:44] = 3'(dx - sx);
      end else begin
         p[46:44] = 3'(sx - dx);
      end
      if (d < MESH_X)          p[42:40] = 3'd1;
      else if (d < 2 * MESH_X) p[42:40] = 3'd2;
      return p;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         wr_ready_q  <= 1'b0;
         pkt_valid_q <= 1'b0;
         pkt_data_q  <= '0;
         addr_err_q  <= 1'b0;
         cnt_q       <= '0;
         row_q       <= '0;
         bank_q      <= '0;
      end else begin
         case (state_q)
            IDLE: if (load_start) begin
               state_q    <= LOAD;
               wr_ready_q <= 1'b1;
               addr_err_q <= 1'b0;
               cnt_q      <= '0;
            end
            LOAD: begin
               if (beat) begin
                  cnt_q <= cnt_q + CW'(1);
                  if (addr_ok) bank_q[wr_row][int'(wr_col)*WIDTH_data +: WIDTH_data] <= wr_data;
                  else         addr_err_q <= 1'b1;
               end
               if (load_done) begin
                  state_q    <= SEND;
                  wr_ready_q <= 1'b0;
                  row_q      <= '0;
               end else if (beat && cnt_q == CNT_LAST) begin
                  state_q    <= WAIT_DONE;
                  wr_ready_q <= 1'b0;
               end
            end
            WAIT_DONE: if (load_done) begin
               state_q <= SEND;
               row_q   <= '0;
            end
            SEND: begin
               if (send_go) begin
                  pkt_data_q  <= build_pkt(row_q, bank_q[row_q]);
                  pkt_valid_q <= 1'b1;
               end else if (pkt_valid_q && pkt_ready) begin
                  pkt_valid_q <= 1'b0;
                  if (row_q == ROW_LAST) begin
                     state_q <= DONE;
                     row_q   <= '0;
                  end else begin
                     row_q   <= row_q + RW'(1);
                  end
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign wr_ready  = wr_ready_q;
   assign pkt_valid = pkt_valid_q;
   assign pkt_data  = pkt_data_q;
   assign addr_err  = addr_err_q;
   assign busy      = (state_q != IDLE);

endmodule
